regfile_access_bridge: RTL
==========================

# regfile_access_bridge

Command-driven initiator for the 32×64 `RegisterFile` write/read ports. It accepts read and byte-masked write commands over a valid/ready handshake and drives `reg_write`/`w_addr`/`w_data` and `r_addr1`/`r_data1`. It performs read-modify-write for partial masks and returns exactly one response per command over a second valid/ready handshake. It sits between the debug/JTAG command path and the register file, so the register file needs no byte-mask support.

## Interface
- `DATA_W`, 64, data width; must be a multiple of 8; vectors are `[0:DATA_W-1]`.
- `ADDR_W`, 5, register address width.
- `NUM_REGS`, 32, number of implemented registers; addresses ≥ NUM_REGS are rejected.
- `READ_LAT`, 1, cycles `r_addr1` is held before `r_data1` is sampled (≥1). 1 means a combinational regfile read.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `srst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  bridge accepts the command this cycle.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  target register.
- `cmd_wdata`  in  DATA_W  write data.
- `cmd_wmask`  in  DATA_W/8  byte enables; bit k covers data `[8k:8k+7]`, so bit 0 covers `[0:7]`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  DATA_W  read value, or final written value.
- `resp_err`  out  1  address out of range; no access performed.
- `reg_write`  out  1  to regfile write enable.
- `w_addr`  out  ADDR_W  to regfile write address.
- `w_data`  out  DATA_W  to regfile write data.
- `r_addr1`  out  ADDR_W  to regfile read address.
- `r_data1`  in  DATA_W  from regfile read data.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE: `cmd_ready=1`. Handshake is `cmd_valid & cmd_ready`. On handshake the bridge latches write, addr, wdata and wmask, then branches:
  - addr ≥ NUM_REGS → RESP with `resp_err=1`, `resp_rdata=0`.
  - write with mask all-ones → WR.
  - read, or write with any other mask (including all-zero) → RD.
- RD: drive `r_addr1`=addr for READ_LAT cycles, then sample `r_data1` into the data register on the last edge. Then:
  - read, or write with mask 0 → RESP, with rdata = sampled value.
  - partial write → merge, then WR. The merged byte k is the wdata byte if mask[k] is set, otherwise the sampled byte.
- WR: exactly one cycle with `reg_write=1`, `w_addr`=addr, `w_data`=final value. Then RESP with `resp_rdata`=final value and `resp_err=0`.
- RESP: `resp_valid=1`. Response fields are stable until `resp_ready`. On handshake → IDLE.
- `cmd_ready=0` in every state except IDLE. There is no command pipelining; one command is in flight at a time.
- `reg_write` is never asserted outside WR. A write with mask 0 performs no write.
- The bridge performs no special handling of any address, including 0; regfile semantics apply.

## Timing
- Reset values (cycle after an edge with `srst=1`): state IDLE, `cmd_ready=1`, `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `reg_write=0`, `w_addr=0`, `w_data=0`, `r_addr1=0`.
- `w_addr`, `w_data` and `r_addr1` return to 0 in any cycle where they are not in use.
- `srst` mid-operation aborts at that edge:
  - a pending response is dropped;
  - a WR cycle coinciding with the `srst` edge is the regfile's concern;
  - the bridge issues no further write.
- Latency from the accept edge (cycle 0) to first `resp_valid` cycle:
  - full write: 2 (WR in cycle 1);
  - read or mask-0 write: 1+READ_LAT;
  - partial write: 2+READ_LAT;
  - out-of-range: 1.
- `resp_ready` held high in RESP gives one response cycle. Back-to-back throughput for full writes is therefore one command per 3 cycles.
- `resp_valid` low with `resp_ready` high has no effect.

## Test plan
- Reset, then full writes of `reg[i]=i+15` for i=1..7 and `reg[0]=0xFF` (mask 0xFF) → each response `resp_err=0` and rdata echoes the data. Exactly one `reg_write` pulse per command, in cycle 1 after accept.
- Read addresses 0..7 in order, then 7..0 → rdata 0xFF, 16..22 matching. `resp_valid` appears 1+READ_LAT cycles after each accept; `reg_write` never asserts.
- `reg[5]=0x0011223344556677`, then write data 0xFFFFFFFFFFFFFFFF mask 0x81 → written and returned value 0xFF112233445566FF. Sequence is an RD cycle then a WR cycle; a read of 5 confirms the value.
- Write to 4 with mask 0x00 → no `reg_write`; response returns the current `reg[4]`.
- With NUM_REGS=8, command to address 9 → response 1 cycle after accept with `resp_err=1`, rdata 0, no regfile activity.
- Hold `resp_ready=0` for 5 cycles during a read → `resp_valid` and rdata stable and `cmd_ready=0` throughout. Assert `srst` in RD of a partial write → no `reg_write`, outputs at reset values next cycle, target register unchanged.

Source files
------------

// File: rtl/regfile_access_bridge.sv
// Command-driven initiator for the RegisterFile write/read ports: reads, full writes,
// and byte-masked writes by read-modify-write, one response per accepted command.
module regfile_access_bridge #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [0:DATA_W-1]   cmd_wdata,
  input  logic [0:DATA_W/8-1] cmd_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [0:DATA_W-1]   resp_rdata,
  output logic                resp_err,
  output logic                reg_write,
  output logic [ADDR_W-1:0]   w_addr,
  output logic [0:DATA_W-1]   w_data,
  output logic [ADDR_W-1:0]   r_addr1,
  input  logic [0:DATA_W-1]   r_data1
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  // Byte k of the result is taken from new_v when mask[k] is set, else from old_v.
  function automatic logic [0:DATA_W-1] merge_bytes(input logic [0:DATA_W-1] old_v,
                                                    input logic [0:DATA_W-1] new_v,
                                                    input logic [0:NB-1]     mask);
    logic [0:DATA_W-1] res;
    res = old_v;
    for (int k = 0; k < int'(NB); k++) begin
      if (mask[k]) begin
        res[8*k +: 8] = new_v[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_v[8*k +: 8];
      end
    end
    return res;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic                is_write_r, is_write_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [0:DATA_W-1]   wdata_r, wdata_nxt_s;
  logic [0:NB-1]       wmask_r, wmask_nxt_s;
  logic [0:DATA_W-1]   data_r, data_nxt_s;
  logic                err_r, err_nxt_s;

  // Next-state and command/data bookkeeping.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    is_write_nxt_s = is_write_r;
    addr_nxt_s     = addr_r;
    wdata_nxt_s    = wdata_r;
    wmask_nxt_s    = wmask_r;
    data_nxt_s     = data_r;
    err_nxt_s      = err_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          is_write_nxt_s = cmd_write;
          addr_nxt_s     = cmd_addr;
          wdata_nxt_s    = cmd_wdata;
          wmask_nxt_s    = cmd_wmask;
          cnt_nxt_s      = {CNT_W{1'b0}};
          if (32'(cmd_addr) >= NUM_REGS) begin
            err_nxt_s   = 1'b1;
            data_nxt_s  = {DATA_W{1'b0}};
            state_nxt_s = RESP;
          end else if (cmd_write && (&cmd_wmask)) begin
            err_nxt_s   = 1'b0;
            data_nxt_s  = cmd_wdata;
            state_nxt_s = WR;
          end else begin
            err_nxt_s   = 1'b0;
            data_nxt_s  = {DATA_W{1'b0}};
            state_nxt_s = RD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD: begin
        if (cnt_r == CNT_LAST) begin
          // A mask-0 write degenerates into a read: nothing to merge, nothing to write.
          if (is_write_r && (|wmask_r)) begin
            data_nxt_s  = merge_bytes(r_data1, wdata_r, wmask_r);
            state_nxt_s = WR;
          end else begin
            data_nxt_s  = r_data1;
            state_nxt_s = RESP;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      WR: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, bookkeeping and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      is_write_r <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      wmask_r    <= {NB{1'b0}};
      data_r     <= {DATA_W{1'b0}};
      err_r      <= 1'b0;
      cmd_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= {DATA_W{1'b0}};
      reg_write  <= 1'b0;
      w_addr     <= {ADDR_W{1'b0}};
      w_data     <= {DATA_W{1'b0}};
      r_addr1    <= {ADDR_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      is_write_r <= is_write_nxt_s;
      addr_r     <= addr_nxt_s;
      wdata_r    <= wdata_nxt_s;
      wmask_r    <= wmask_nxt_s;
      data_r     <= data_nxt_s;
      err_r      <= err_nxt_s;
      cmd_ready  <= (state_nxt_s == IDLE);
      resp_valid <= (state_nxt_s == RESP);
      resp_err   <= (state_nxt_s == RESP) ? err_nxt_s : 1'b0;
      resp_rdata <= (state_nxt_s == RESP) ? data_nxt_s : {DATA_W{1'b0}};
      reg_write  <= (state_nxt_s == WR);
      w_addr     <= (state_nxt_s == WR) ? addr_nxt_s : {ADDR_W{1'b0}};
      w_data     <= (state_nxt_s == WR) ? data_nxt_s : {DATA_W{1'b0}};
      r_addr1    <= (state_nxt_s == RD) ? addr_nxt_s : {ADDR_W{1'b0}};
    end
  end

endmodule
